cpu_csr_unit: RTL and testbench

Parametrised supervisor/user-mode control-and-status register unit for the CPU core, sitting beside the execute stage. It provides:
- CSRRW/CSRRS/CSRRC read-modify-write access with privilege and counter-enable checking;
- configurable-width cycle/time/instret counters plus HPM_COUNT hardware performance counters;
- prioritised interrupt selection, trap entry/return state updates and direct or vectored trap target generation.

---
 rtl/cpu_csr_unit.sv | 207 ++++++++++++++++++++
 tb/tb_cpu_csr_unit.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_csr_unit.sv
// rtl/cpu_csr_unit.sv - supervisor/user CSR unit: counters, interrupt select, trap entry/return, trap targets
// Optional feature macro: CSR_VECTORED_EN (stvec bit0 writable, vectored interrupt targets).
module cpu_csr_unit #(
  parameter int HPM_COUNT = 4,
  parameter int CNT_WIDTH = 64
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [11:0]                                csr_addr,
  input  logic [1:0]                                 csr_op,
  input  logic [31:0]                                csr_wdata,
  output logic [31:0]                                csr_rdata,
  output logic                                       csr_illegal,
  input  logic                                       inst_tick,
  input  logic                                       timer_tick,
  input  logic                                       ext_intr,
  input  logic [(HPM_COUNT > 0 ? HPM_COUNT : 1)-1:0] hpm_event,
  input  logic                                       trap_enter,
  input  logic                                       trap_is_intr,
  input  logic [4:0]                                 trap_code,
  input  logic [31:0]                                trap_pc,
  input  logic [31:0]                                trap_value,
  input  logic                                       trap_return,
  output logic [31:0]                                trap_target,
  output logic [31:0]                                return_target,
  output logic                                       intr_pending,
  output logic [4:0]                                 intr_code,
  output logic                                       priv_s
);

  localparam int NCNT = HPM_COUNT + 3;
  localparam int HPM_DEPTH = (HPM_COUNT > 0) ? HPM_COUNT : 1;
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;
  localparam logic [31:0] SIE_MASK = 32'h0000_0222;
  localparam logic [31:0] SIP_SW_MASK = 32'h0000_0022;
  localparam logic [63:0] SCEN_MASK64 = (64'd1 << NCNT) - 64'd1;
  localparam logic [31:0] SCEN_MASK = SCEN_MASK64[31:0];
`ifdef CSR_VECTORED_EN
  localparam logic [31:0] STVEC_MASK = 32'hFFFF_FFFD;
`else
  localparam logic [31:0] STVEC_MASK = 32'hFFFF_FFFC;
`endif

  logic                 sie_b, spie, spp;
  logic [31:0]          sie_r, stvec_r, scounteren_r, sscratch_r, sepc_r, scause_r, stval_r, sip_sw;
  logic                 ext_q;
  logic [CNT_WIDTH-1:0] cycle_cnt, time_cnt, instret_cnt;
  logic [CNT_WIDTH-1:0] hpm_cnt [HPM_DEPTH];

  logic [31:0]          sstatus_val, sip_val, old_val, new_val, pend, tvec_base;
  logic                 csr_exists, cnt_hit, wr_intent, wr_en;
  logic [4:0]           cnt_idx;
  logic [CNT_WIDTH-1:0] cnt_sel;
  logic [63:0]          cnt_ext;

  assign sstatus_val = {23'd0, spp, 2'b00, spie, 3'b000, sie_b, 1'b0};
  assign sip_val = sip_sw | {22'd0, ext_q, 9'd0};
  assign cnt_idx = csr_addr[4:0];
  assign cnt_hit = (csr_addr[11:8] == 4'hC) && (csr_addr[6:5] == 2'b00) &&
                   ({1'b0, csr_addr[4:0]} < 6'(NCNT));
  assign return_target = sepc_r;

  // Decode the addressed CSR into its current value and whether it is implemented
  always_comb begin
    old_val = 32'd0;
    csr_exists = 1'b0;
    cnt_sel = '0;
    case (cnt_idx)
      5'd0: cnt_sel = cycle_cnt;
      5'd1: cnt_sel = time_cnt;
      5'd2: cnt_sel = instret_cnt;
      default: begin
        for (int k = 0; k < HPM_COUNT; k++) begin
          if (cnt_idx == 5'(k + 3)) cnt_sel = hpm_cnt[k];
        end
      end
    endcase
    cnt_ext = 64'(cnt_sel);
    if (cnt_hit) begin
      csr_exists = 1'b1;
      old_val = csr_addr[7] ? cnt_ext[63:32] : cnt_ext[31:0];
    end else begin
      csr_exists = 1'b1;
      case (csr_addr)
        12'h100: old_val = sstatus_val;
        12'h104: old_val = sie_r;
        12'h105: old_val = stvec_r;
        12'h106: old_val = scounteren_r;
        12'h140: old_val = sscratch_r;
        12'h141: old_val = sepc_r;
        12'h142: old_val = scause_r;
        12'h143: old_val = stval_r;
        12'h144: old_val = sip_val;
        default: csr_exists = 1'b0;
      endcase
    end
  end

  // Access checking, read data and the read-modify-write result
  always_comb begin
    wr_intent = (csr_op == OP_RW) || (csr_wdata != 32'd0);
    csr_illegal = (csr_op != OP_NONE) &&
                  (!csr_exists ||
                   (!priv_s && csr_addr[9:8] == 2'b01) ||
                   (cnt_hit && !priv_s && !scounteren_r[cnt_idx]) ||
                   (csr_addr[11:10] == 2'b11 && wr_intent));
    csr_rdata = (csr_op != OP_NONE && !csr_illegal) ? old_val : 32'd0;
    case (csr_op)
      OP_RW:   new_val = csr_wdata;
      OP_RS:   new_val = old_val | csr_wdata;
      OP_RC:   new_val = old_val & ~csr_wdata;
      default: new_val = old_val;
    endcase
    wr_en = (csr_op != OP_NONE) && !csr_illegal && !trap_enter && !trap_return;
  end

  // Free-running and event counters; they wrap naturally at CNT_WIDTH
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
      time_cnt <= '0;
      instret_cnt <= '0;
      for (int k = 0; k < HPM_DEPTH; k++) hpm_cnt[k] <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
      if (timer_tick) time_cnt <= time_cnt + CNT_WIDTH'(1);
      if (inst_tick) instret_cnt <= instret_cnt + CNT_WIDTH'(1);
      for (int k = 0; k < HPM_COUNT; k++) begin
        if (hpm_event[k]) hpm_cnt[k] <= hpm_cnt[k] + CNT_WIDTH'(1);
      end
    end
  end

  // CSR writes, timer pending set, and trap entry/return state (trap_enter wins)
  always_ff @(posedge clk) begin
    if (rst) begin
      priv_s <= 1'b1;
      sie_b <= 1'b0;
      spie <= 1'b0;
      spp <= 1'b0;
      sie_r <= '0;
      stvec_r <= '0;
      scounteren_r <= '0;
      sscratch_r <= '0;
      sepc_r <= '0;
      scause_r <= '0;
      stval_r <= '0;
      sip_sw <= '0;
      ext_q <= 1'b0;
    end else begin
      ext_q <= ext_intr;
      if (wr_en) begin
        case (csr_addr)
          12'h100: begin
            sie_b <= new_val[1];
            spie <= new_val[5];
            spp <= new_val[8];
          end
          12'h104: sie_r <= new_val & SIE_MASK;
          12'h105: stvec_r <= new_val & STVEC_MASK;
          12'h106: scounteren_r <= new_val & SCEN_MASK;
          12'h140: sscratch_r <= new_val;
          12'h141: sepc_r <= new_val & 32'hFFFF_FFFC;
          12'h142: scause_r <= new_val;
          12'h143: stval_r <= new_val;
          12'h144: sip_sw <= new_val & SIP_SW_MASK;
          default: ;
        endcase
      end
      if (timer_tick) sip_sw[5] <= 1'b1;
      if (trap_enter) begin
        sepc_r <= {trap_pc[31:2], 2'b00};
        scause_r <= {trap_is_intr, 26'd0, trap_code};
        stval_r <= trap_value;
        spp <= priv_s;
        spie <= sie_b;
        sie_b <= 1'b0;
        priv_s <= 1'b1;
      end else if (trap_return) begin
        priv_s <= spp;
        sie_b <= spie;
        spie <= 1'b1;
        spp <= 1'b0;
      end
    end
  end

  // Interrupt priority (9 > 1 > 5) and trap handler address
  always_comb begin
    pend = sip_val & sie_r;
    intr_pending = (|pend) && (!priv_s || sie_b);
    if (pend[9]) intr_code = 5'd9;
    else if (pend[1]) intr_code = 5'd1;
    else if (pend[5]) intr_code = 5'd5;
    else intr_code = 5'd0;
    tvec_base = {stvec_r[31:2], 2'b00};
`ifdef CSR_VECTORED_EN
    trap_target = (stvec_r[0] && trap_is_intr) ? tvec_base + {25'd0, trap_code, 2'b00} : tvec_base;
`else
    trap_target = tvec_base;
`endif
  end

endmodule

// File: tb/tb_cpu_csr_unit.sv
// tb/tb_cpu_csr_unit.sv - directed table-driven bench for cpu_csr_unit
module tb_cpu_csr_unit;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;
`ifdef CSR_VECTORED_EN
  localparam logic [31:0] STVEC_RB = 32'h0000_1001;
  localparam logic [31:0] TT_EXP = 32'h0000_1024;
`else
  localparam logic [31:0] STVEC_RB = 32'h0000_1000;
  localparam logic [31:0] TT_EXP = 32'h0000_1000;
`endif

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_ill;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [11:0] csr_addr = '0;
  logic [1:0] csr_op = '0;
  logic [31:0] csr_wdata = '0;
  logic inst_tick = 1'b0, timer_tick = 1'b0, ext_intr = 1'b0;
  logic [3:0] hpm_event = '0;
  logic trap_enter = 1'b0, trap_is_intr = 1'b0, trap_return = 1'b0;
  logic [4:0] trap_code = '0;
  logic [31:0] trap_pc = '0, trap_value = '0;

  logic [31:0] csr_rdata, trap_target, return_target;
  logic csr_illegal, intr_pending, priv_s;
  logic [4:0] intr_code;
  logic [31:0] d33_rdata, d33_trap_target, d33_return_target;
  logic d33_illegal, d33_intr_pending, d33_priv_s;
  logic [4:0] d33_intr_code;

  int n_chk = 0;
  int n_pass = 0;
  int tb_cyc = 0;
  vec_t vecs [$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) tb_cyc <= 0;
    else tb_cyc <= tb_cyc + 1;
  end

  cpu_csr_unit u_dut (
    .clk(clk), .rst(rst), .csr_addr(csr_addr), .csr_op(csr_op), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .inst_tick(inst_tick),
    .timer_tick(timer_tick), .ext_intr(ext_intr), .hpm_event(hpm_event),
    .trap_enter(trap_enter), .trap_is_intr(trap_is_intr), .trap_code(trap_code),
    .trap_pc(trap_pc), .trap_value(trap_value), .trap_return(trap_return),
    .trap_target(trap_target), .return_target(return_target),
    .intr_pending(intr_pending), .intr_code(intr_code), .priv_s(priv_s)
  );

  cpu_csr_unit #(.CNT_WIDTH(33)) u_dut33 (
    .clk(clk), .rst(rst), .csr_addr(csr_addr), .csr_op(csr_op), .csr_wdata(csr_wdata),
    .csr_rdata(d33_rdata), .csr_illegal(d33_illegal), .inst_tick(inst_tick),
    .timer_tick(timer_tick), .ext_intr(ext_intr), .hpm_event(hpm_event),
    .trap_enter(trap_enter), .trap_is_intr(trap_is_intr), .trap_code(trap_code),
    .trap_pc(trap_pc), .trap_value(trap_value), .trap_return(trap_return),
    .trap_target(d33_trap_target), .return_target(d33_return_target),
    .intr_pending(d33_intr_pending), .intr_code(d33_intr_code), .priv_s(d33_priv_s)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic next_cycle();
    @(negedge clk);
    csr_op = OP_NONE;
    csr_addr = '0;
    csr_wdata = '0;
    timer_tick = 1'b0;
    inst_tick = 1'b0;
    hpm_event = '0;
    trap_enter = 1'b0;
    trap_return = 1'b0;
    trap_is_intr = 1'b0;
    trap_code = '0;
    trap_pc = '0;
    trap_value = '0;
  endtask

  task automatic acc(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
    next_cycle();
    csr_op = op;
    csr_addr = addr;
    csr_wdata = wd;
    #2;
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    ext_intr = 1'b0;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic add(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                     input logic [31:0] er, input logic ei);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wd; v.exp_rdata = er; v.exp_ill = ei;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    add(OP_RS, 12'h100, 32'h0,         32'h0,         1'b0);
    add(OP_RS, 12'h105, 32'h0,         32'h0,         1'b0);
    add(OP_RW, 12'h100, 32'hFFFF_FFFF, 32'h0,         1'b0);
    add(OP_RS, 12'h100, 32'h0,         32'h0000_0122, 1'b0);
    add(OP_RC, 12'h100, 32'h2,         32'h0000_0122, 1'b0);
    add(OP_RS, 12'h100, 32'h0,         32'h0000_0120, 1'b0);
    add(OP_RW, 12'h140, 32'hDEAD_BEEF, 32'h0,         1'b0);
    add(OP_RS, 12'h140, 32'h0,         32'hDEAD_BEEF, 1'b0);
    add(OP_RS, 12'h140, 32'h0000_000F, 32'hDEAD_BEEF, 1'b0);
    add(OP_RC, 12'h140, 32'hFFFF_0000, 32'hDEAD_BEEF, 1'b0);
    add(OP_RS, 12'h140, 32'h0,         32'h0000_BEEF, 1'b0);
    add(OP_RW, 12'h104, 32'hFFFF_FFFF, 32'h0,         1'b0);
    add(OP_RS, 12'h104, 32'h0,         32'h0000_0222, 1'b0);
    add(OP_RW, 12'h141, 32'h1234_5677, 32'h0,         1'b0);
    add(OP_RS, 12'h141, 32'h0,         32'h1234_5674, 1'b0);
    add(OP_RW, 12'h106, 32'hFFFF_FFFF, 32'h0,         1'b0);
    add(OP_RS, 12'h106, 32'h0,         32'h0000_007F, 1'b0);
    add(OP_RW, 12'h144, 32'hFFFF_FFFF, 32'h0,         1'b0);
    add(OP_RS, 12'h144, 32'h0,         32'h0000_0022, 1'b0);
    add(OP_RW, 12'h123, 32'h5,         32'h0,         1'b1);
    add(OP_RW, 12'hC00, 32'h0,         32'h0,         1'b1);
    add(OP_RS, 12'hC00, 32'h1,         32'h0,         1'b1);
    add(OP_RC, 12'hC80, 32'h0,         32'h0,         1'b0);
    add(OP_RS, 12'hC07, 32'h0,         32'h0,         1'b1);
    add(OP_RS, 12'hC03, 32'h0,         32'h0,         1'b0);
    add(OP_NONE, 12'h140, 32'h0,       32'h0,         1'b0);
    add(OP_RW, 12'h105, 32'h1003,      32'h0,         1'b0);
    add(OP_RS, 12'h105, 32'h0,         STVEC_RB,      1'b0);

    // reset state, sampled while rst is still held
    next_cycle();
    rst = 1'b1;
    next_cycle();
    csr_op = OP_RS;
    csr_addr = 12'h100;
    #2;
    chk("reset sstatus", csr_rdata, 32'h0);
    chk1("reset illegal", csr_illegal, 1'b0);
    chk1("reset priv_s", priv_s, 1'b1);
    chk1("reset intr_pending", intr_pending, 1'b0);
    chk("reset intr_code", {27'd0, intr_code}, 32'h0);
    chk("reset trap_target", trap_target, 32'h0);
    chk("reset return_target", return_target, 32'h0);
    next_cycle();
    rst = 1'b0;
    acc(OP_RS, 12'hC00, 32'h0);
    chk("cycle after reset", csr_rdata, 32'(tb_cyc));

    foreach (vecs[i]) begin
      acc(vecs[i].op, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("vec%0d rdata", i), csr_rdata, vecs[i].exp_rdata);
      chk1($sformatf("vec%0d illegal", i), csr_illegal, vecs[i].exp_ill);
    end
    chk("table intr_code", {27'd0, intr_code}, 32'd1);
    chk1("table intr_pending SIE=0", intr_pending, 1'b0);

    // reset during a write and a trap performs reset only
    next_cycle();
    rst = 1'b1;
    csr_op = OP_RW; csr_addr = 12'h140; csr_wdata = 32'h77;
    trap_enter = 1'b1; trap_pc = 32'h44;
    next_cycle();
    rst = 1'b0;
    csr_op = OP_RS; csr_addr = 12'h140;
    #2;
    chk("rst beats write sscratch", csr_rdata, 32'h0);
    chk("rst beats trap sepc", return_target, 32'h0);
    chk1("rst beats trap priv_s", priv_s, 1'b1);

    // external interrupt, trap entry, write suppression, trap return
    acc(OP_RW, 12'h105, 32'h1001);
    acc(OP_RW, 12'h104, 32'h200);
    acc(OP_RW, 12'h100, 32'h2);
    next_cycle();
    ext_intr = 1'b1;
    #2;
    chk1("ext_intr register delay", intr_pending, 1'b0);
    next_cycle();
    trap_code = 5'd9;
    #2;
    chk1("ext intr pending", intr_pending, 1'b1);
    chk("ext intr code", {27'd0, intr_code}, 32'd9);
    chk("exception target", trap_target, 32'h1000);
    next_cycle();
    trap_enter = 1'b1; trap_is_intr = 1'b1; trap_code = 5'd9; trap_pc = 32'h8000_0010;
    csr_op = OP_RW; csr_addr = 12'h140; csr_wdata = 32'h55;
    #2;
    chk("intr trap_target", trap_target, TT_EXP);
    chk("rdata during trap", csr_rdata, 32'h0);
    chk1("illegal during trap", csr_illegal, 1'b0);
    acc(OP_RS, 12'h142, 32'h0);
    chk("scause intr", csr_rdata, 32'h8000_0009);
    chk("sepc intr", return_target, 32'h8000_0010);
    chk1("priv_s after trap", priv_s, 1'b1);
    chk1("intr masked after trap", intr_pending, 1'b0);
    acc(OP_RS, 12'h100, 32'h0);
    chk("sstatus after trap", csr_rdata, 32'h120);
    acc(OP_RS, 12'h140, 32'h0);
    chk("write suppressed by trap", csr_rdata, 32'h0);
    next_cycle();
    trap_return = 1'b1;
    acc(OP_RS, 12'h100, 32'h0);
    chk("sstatus after sret", csr_rdata, 32'h22);
    chk1("priv_s after sret SPP=1", priv_s, 1'b1);
    next_cycle();
    trap_enter = 1'b1; trap_return = 1'b1; trap_pc = 32'h200; trap_code = 5'd3;
    acc(OP_RS, 12'h100, 32'h0);
    chk("enter beats return sstatus", csr_rdata, 32'h120);
    chk("enter beats return sepc", return_target, 32'h200);

    // U-mode entry, counter gating and trap from U-mode
    do_reset();
    acc(OP_RW, 12'h100, 32'h20);
    next_cycle();
    trap_return = 1'b1;
    next_cycle();
    #2;
    chk1("priv_s U-mode", priv_s, 1'b0);
    acc(OP_RS, 12'hC00, 32'h0);
    chk1("U cycle gated illegal", csr_illegal, 1'b1);
    chk("U cycle gated rdata", csr_rdata, 32'h0);
    acc(OP_RS, 12'h140, 32'h0);
    chk1("U sscratch illegal", csr_illegal, 1'b1);
    next_cycle();
    trap_enter = 1'b1; trap_pc = 32'h8000_0006; trap_code = 5'd2; trap_value = 32'hBAD;
    next_cycle();
    #2;
    chk1("priv_s after U trap", priv_s, 1'b1);
    chk("sepc aligned", return_target, 32'h8000_0004);
    acc(OP_RS, 12'h100, 32'h0);
    chk("sstatus after U trap", csr_rdata, 32'h20);
    acc(OP_RS, 12'h143, 32'h0);
    chk("stval", csr_rdata, 32'hBAD);
    acc(OP_RS, 12'h142, 32'h0);
    chk("scause exc", csr_rdata, 32'h2);
    acc(OP_RW, 12'h106, 32'h1);
    next_cycle();
    trap_return = 1'b1;
    next_cycle();
    #2;
    chk1("priv_s back to U", priv_s, 1'b0);
    acc(OP_RS, 12'hC00, 32'h0);
    chk1("U cycle enabled legal", csr_illegal, 1'b0);
    chk("U cycle enabled rdata", csr_rdata, 32'(tb_cyc));
    acc(OP_RS, 12'hC01, 32'h0);
    chk1("U time gated illegal", csr_illegal, 1'b1);
    next_cycle();
    trap_enter = 1'b1;
    acc(OP_RS, 12'h100, 32'h0);
    chk("SIE restored then saved", csr_rdata, 32'h20);

    // timer tick vs software clear, counters
    do_reset();
    next_cycle();
    timer_tick = 1'b1; csr_op = OP_RC; csr_addr = 12'h144; csr_wdata = 32'h20;
    #2;
    chk("sip old before tick", csr_rdata, 32'h0);
    acc(OP_RS, 12'h144, 32'h0);
    chk("tick beats clear", csr_rdata, 32'h20);
    acc(OP_RC, 12'h144, 32'h20);
    acc(OP_RS, 12'h144, 32'h0);
    chk("sip cleared", csr_rdata, 32'h0);
    acc(OP_RS, 12'hC01, 32'h0);
    chk("time count", csr_rdata, 32'h1);
    acc(OP_RW, 12'hC00, 32'h1234);
    chk1("counter write illegal", csr_illegal, 1'b1);
    acc(OP_RS, 12'hC00, 32'h0);
    chk("counter unchanged", csr_rdata, 32'(tb_cyc));
    next_cycle();
    inst_tick = 1'b1; hpm_event = 4'b0100;
    next_cycle();
    inst_tick = 1'b1;
    acc(OP_RS, 12'hC02, 32'h0);
    chk("instret count", csr_rdata, 32'h2);
    acc(OP_RS, 12'hC05, 32'h0);
    chk("hpmcounter5 count", csr_rdata, 32'h1);

    // 33-bit counter wrap
    do_reset();
    next_cycle();
    force u_dut33.cycle_cnt = 33'h1_FFFF_FFFF;
    csr_op = OP_RS; csr_addr = 12'hC80;
    #2;
    chk("w33 upper before wrap", d33_rdata, 32'h1);
    release u_dut33.cycle_cnt;
    acc(OP_RS, 12'hC00, 32'h0);
    chk("w33 low after wrap", d33_rdata, 32'h0);
    acc(OP_RS, 12'hC80, 32'h0);
    chk("w33 high after wrap", d33_rdata, 32'h0);

    next_cycle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
